seven_seg_scan: RTL
===================

// Module: seven_seg_scan
// PURPOSE
//  Multi-digit, time-multiplexed seven-segment driver for the oven front panel.
//  Latches a packed BCD word, scans one digit at a time onto a shared segment bus,
//  and inserts an anti-ghost blank slot between digits.
//  Supports optional leading-zero suppression. Sits between the timer/temperature logic and the board pins.
// PARAMETERS
//  NUM_DIGITS     4      digits driven (1..8)
//  SCAN_DIV       50000  clk cycles per digit slot, blank slot included (>=2)
//  AN_ACTIVE_LOW  1      1: an[i]=0 enables digit i; 0: an[i]=1 enables digit i
//  BLINK_DIV      64     full scan frames per blink half-period (SEVEN_SEG_BLINK_EN only)
// PORTS
//  clk         in   1              system clock, single clock domain
//  rst_n       in   1              asynchronous reset, active low
//  digits_in   in   4*NUM_DIGITS   packed codes, digit i = digits_in[4i+3:4i], digit 0 = LS
//  load        in   1              1-cycle strobe: copy digits_in into the display shadow register
//  lz_blank    in   1              1: suppress leading zeros
//  blink_mask  in   NUM_DIGITS     digits to blink (present only with SEVEN_SEG_BLINK_EN)
//  seg         out  [0:6]          segments a..g, active low (0 = lit), registered
//  an          out  NUM_DIGITS     digit enables, polarity per AN_ACTIVE_LOW, registered
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - prescaler=0, idx=0, state=GAP.
//   - Shadow = all 4'hA (blank).
//   - seg=7'b1111111, an=all inactive.
//  Decode, seg[0:6]:
//   - 0=0000001  1=1001111  2=0010010  3=0000110  4=1001100
//   - 5=0100100  6=0100000  7=0001111  8=0000000  9=0000100
//   - 10..15 = 1111111 (blank)
//  Shadow load:
//   - On clk with load=1, shadow <= digits_in.
//   - Takes effect on the first DRIVE slot that starts after the load; never mid-slot (no tearing).
//   - load while rst_n=0 is ignored.
//  Prescaler:
//   - Counts 0..SCAN_DIV-1 and wraps; tick = (prescaler==SCAN_DIV-1).
//  FSM, two states per slot:
//   - GAP: first cycle of each slot (prescaler==0). an all inactive, seg blank.
//   - DRIVE: prescaler 1..SCAN_DIV-1. an[idx] active only, seg = decode(shadow digit idx).
//   - On tick: idx <= (idx==NUM_DIGITS-1) ? 0 : idx+1.
//   - Outputs are registered: seg/an reflect state/idx one clk later.
//   - Frame = NUM_DIGITS*SCAN_DIV clks.
//  Leading-zero suppression (lz_blank=1):
//   - Digit i is blanked if it and every digit above it equal 0.
//   - Digit 0 is never suppressed, so 0000 shows "0".
//   - Evaluated on the shadow register; lz_blank is sampled at slot start.
//  Mid-operation reset:
//   - All state returns to reset values immediately, outputs go blank.
//   - The scan restarts at digit 0 with a GAP slot after rst_n rises.
// CONFIGURATION
//  SEVEN_SEG_BLINK_EN defined:
//   - Adds the blink_mask port and a frame counter 0..BLINK_DIV-1.
//   - phase toggles when the frame counter wraps; phase=0 at reset.
//   - While phase=1, digits with blink_mask[i]=1 show blank in their DRIVE slot.
//   - an still asserts for those digits (constant duty).
//  SEVEN_SEG_BLINK_EN undefined:
//   - No blink_mask port, no frame counter.
//   - Every digit displays per shadow and lz_blank.
// TESTING (NUM_DIGITS=4, SCAN_DIV=4, AN_ACTIVE_LOW=1, BLINK_DIV=2)
//  1. Reset held, then released with no load:
//     -> seg=1111111 and an=1111 throughout; after release, every DRIVE slot stays blank.
//  2. load digits_in=16'h1234, lz_blank=0:
//     -> per slot: GAP an=1111 for 1 clk, then 3 clks of an=1110/seg=1001100 ("4"),
//        1101/0000110, 1011/0010010, 0111/1001111; wraps to digit 0.
//  3. load 16'h0070, lz_blank=1:
//     -> digits 3 and 2 blank; digit 1 = 0001111; digit 0 = 0000001.
//     -> load 16'h0000 -> only digit 0 lit, "0".
//  4. load 16'h5555 issued mid-DRIVE of digit 1:
//     -> digit 1 keeps its old code until the slot ends; the next slot (digit 2) shows 0100100.
//  5. rst_n pulsed low for 1 clk during digit 2 DRIVE:
//     -> same-cycle async blank; after release, shadow=AAAA and the scan restarts at digit 0 GAP.
//  6. With SEVEN_SEG_BLINK_EN: load 16'h8888, blink_mask=4'b0001:
//     -> digit 0 shows 0000000 for 2 frames, then blank for 2 frames (an still pulsed);
//        digits 1..3 are steady.

Source files
------------

// File: rtl/seven_seg_scan.sv
// Time-multiplexed seven-segment scanner with per-slot anti-ghost blank and leading-zero suppression.
// Optional digit blinking is compiled in when SEVEN_SEG_BLINK_EN is defined.
module seven_seg_scan #(
  parameter int NUM_DIGITS    = 4,
  parameter int SCAN_DIV      = 50000,
  parameter int AN_ACTIVE_LOW = 1,
  parameter int BLINK_DIV     = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [4*NUM_DIGITS-1:0]   digits_in,
  input  logic                      load,
  input  logic                      lz_blank,
`ifdef SEVEN_SEG_BLINK_EN
  input  logic [NUM_DIGITS-1:0]     blink_mask,
`endif
  output logic [0:6]                seg,
  output logic [NUM_DIGITS-1:0]     an
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [NUM_DIGITS-1:0] AN_OFF = (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  typedef enum logic {ST_GAP = 1'b0, ST_DRIVE = 1'b1} state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [PRE_W-1:0]          r_presc;
  logic [IDX_W-1:0]          r_idx;
  logic [4*NUM_DIGITS-1:0]   r_shadow;
  logic [3:0]                r_code;
  logic [6:0]                r_seg;
  logic [NUM_DIGITS-1:0]     r_an;
  logic                      w_tick;
  logic [NUM_DIGITS-1:0]     w_onehot;
  logic [NUM_DIGITS-1:0]     w_lz_mask;
  logic [3:0]                w_cur_digit;
  logic                      w_zero_run;
  logic                      w_slot_blank;
  logic                      w_blink_blank;
  logic [6:0]                w_seg_nxt;
  logic [NUM_DIGITS-1:0]     w_an_nxt;

  function automatic logic [6:0] seg_decode(input logic [3:0] code);
    logic [6:0] s;
    case (code)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  assign w_tick = (r_presc == PRE_W'(SCAN_DIV - 1));

  // Select the current digit and build the leading-zero mask from the shadow word.
  always_comb begin
    w_onehot    = '0;
    w_lz_mask   = '0;
    w_cur_digit = 4'h0;
    w_zero_run  = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_onehot[i]  = (r_idx == IDX_W'(i));
      w_cur_digit  = w_cur_digit | (w_onehot[i] ? r_shadow[4*i +: 4] : 4'h0);
      w_zero_run   = w_zero_run & (r_shadow[4*i +: 4] == 4'h0);
      w_lz_mask[i] = w_zero_run & lz_blank & (i != 0);
    end
  end

`ifdef SEVEN_SEG_BLINK_EN
  localparam int FRM_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  logic [FRM_W-1:0] r_frame;
  logic             r_phase;
  logic             w_frame_end;

  assign w_frame_end   = w_tick & (r_idx == IDX_W'(NUM_DIGITS - 1));
  assign w_blink_blank = r_phase & |(blink_mask & w_onehot);

  // Frame counter; phase flips each time it wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame <= '0;
      r_phase <= 1'b0;
    end else if (w_frame_end) begin
      if (r_frame == FRM_W'(BLINK_DIV - 1)) begin
        r_frame <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_frame <= r_frame + FRM_W'(1);
      end
    end
  end
`else
  assign w_blink_blank = 1'b0;
`endif

  assign w_slot_blank = (|(w_lz_mask & w_onehot)) | w_blink_blank;

  // Next state and next registered outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_seg_nxt   = SEG_BLANK;
    w_an_nxt    = AN_OFF;
    case (r_state)
      ST_GAP: begin
        w_state_nxt = w_tick ? ST_GAP : ST_DRIVE;
      end
      ST_DRIVE: begin
        w_state_nxt = w_tick ? ST_GAP : ST_DRIVE;
        w_seg_nxt   = seg_decode(r_code);
        w_an_nxt    = (AN_ACTIVE_LOW != 0) ? ~w_onehot : w_onehot;
      end
      default: begin
        w_state_nxt = ST_GAP;
      end
    endcase
  end

  // Prescaler, digit index and state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_idx   <= '0;
      r_state <= ST_GAP;
    end else begin
      r_state <= w_state_nxt;
      if (w_tick) begin
        r_presc <= '0;
        r_idx   <= (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
      end else begin
        r_presc <= r_presc + PRE_W'(1);
      end
    end
  end

  // Shadow register; the slot code is frozen during GAP so a load never tears a slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= {NUM_DIGITS{4'hA}};
      r_code   <= 4'hA;
    end else begin
      if (load) begin
        r_shadow <= digits_in;
      end
      if (r_state == ST_GAP) begin
        r_code <= w_slot_blank ? 4'hF : w_cur_digit;
      end
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg <= SEG_BLANK;
      r_an  <= AN_OFF;
    end else begin
      r_seg <= w_seg_nxt;
      r_an  <= w_an_nxt;
    end
  end

  assign seg = r_seg;
  assign an  = r_an;

endmodule
